// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared constants, helpers and types for the parametrised synchronous FIFO.
//   DEF_DATA_W / DEF_DEPTH : default data width and depth
//   addr_w()               : storage index width for a given depth
//   ptr_w()                : pointer width (index bits plus one wrap bit)
//   count_t                : occupancy type for the default depth (0..DEPTH)
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  // Number of bits needed to index DEPTH storage entries.
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Pointer width: index bits plus a wrap bit that separates full from empty.
  function automatic int ptr_w(input int depth);
    return addr_w(depth) + 1;
  endfunction

  // Occupancy must represent 0..DEPTH inclusive, hence one bit above the index.
  typedef logic [$clog2(DEF_DEPTH):0] count_t;

endpackage : fifo_pkg

// File: rtl/fifo_ram.sv
// ---------------------------------------------------------------------------
// fifo_ram
// DEPTH x DATA_W storage with one synchronous write port and one synchronous
// registered read port. The storage array is not reset; only the read data
// register is cleared so the FIFO output is defined after reset.
// Ports:
//   clk    : clock, all updates on the rising edge
//   rst    : asynchronous active-low reset (read data register only)
//   we     : write strobe
//   waddr  : write index
//   wdata  : write data
//   re     : read strobe; rdata updates only when re is high
//   raddr  : read index
//   rdata  : registered read data, holds when re is low
// ---------------------------------------------------------------------------
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // Storage write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; holds the last read word when no read occurs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_r <= {DATA_W{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule : fifo_ram

// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
// Parametrised single-clock FIFO with simultaneous read/write, occupancy
// count, programmable almost-full / almost-empty thresholds and optional
// sticky error flags.
//
// Configuration macro: SYNC_FIFO_ERR_EN
//   defined   : overflow / underflow are sticky registers cleared by err_clr
//   undefined : overflow / underflow are constant 0 and err_clr is ignored
//
// Ports:
//   clk          : clock, all state changes on the rising edge
//   rst          : asynchronous active-low reset
//   write_en     : write request (accepted when not full)
//   data_in      : write data
//   read_en      : read request (accepted when not empty)
//   data_out     : registered read data, valid the cycle after a read
//   full         : count == DEPTH
//   empty        : count == 0
//   almost_full  : count >= AF_LVL
//   almost_empty : count <= AE_LVL
//   count        : occupancy 0..DEPTH
//   overflow     : sticky, write attempted while full
//   underflow    : sticky, read attempted while empty
//   err_clr      : clears overflow and underflow (a same-cycle set wins)
// ---------------------------------------------------------------------------
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     write_en,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     read_en,
  output logic [DATA_W-1:0]        data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     err_clr
);

  localparam int AW = addr_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] AF_CNT    = CW'(AF_LVL);
  localparam logic [CW-1:0] AE_CNT    = CW'(AE_LVL);
  localparam logic [PW-1:0] PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          full_r;
  logic          empty_r;
  logic          af_r;
  logic          ae_r;

  logic          wr_ok_s;
  logic          rd_ok_s;
  logic [PW-1:0] wr_ptr_nxt_s;
  logic [PW-1:0] rd_ptr_nxt_s;
  logic [CW-1:0] count_nxt_s;
  logic          full_nxt_s;
  logic          empty_nxt_s;
  logic          af_nxt_s;
  logic          ae_nxt_s;

  // Acceptance is judged against the registered (pre-edge) flags, so a full
  // FIFO accepts only the read and an empty FIFO accepts only the write.
  assign wr_ok_s = write_en & ~full_r;
  assign rd_ok_s = read_en & ~empty_r;

  // Next pointers, occupancy and status flags.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;

    if (wr_ok_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end

    if (rd_ok_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end

    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase

    // Wrap bits differ with equal indices: writer is a full lap ahead.
    full_nxt_s  = (wr_ptr_nxt_s[PW-1] != rd_ptr_nxt_s[PW-1]) &&
                  (wr_ptr_nxt_s[AW-1:0] == rd_ptr_nxt_s[AW-1:0]);
    empty_nxt_s = (wr_ptr_nxt_s == rd_ptr_nxt_s);
    af_nxt_s    = (count_nxt_s >= AF_CNT);
    ae_nxt_s    = (count_nxt_s <= AE_CNT);
  end

  // Pointer, count and flag registers; flags follow the post-edge state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      af_r     <= 1'b0;
      ae_r     <= 1'b1;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      full_r   <= full_nxt_s;
      empty_r  <= empty_nxt_s;
      af_r     <= af_nxt_s;
      ae_r     <= ae_nxt_s;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok_s),
    .waddr (wr_ptr_r[AW-1:0]),
    .wdata (data_in),
    .re    (rd_ok_s),
    .raddr (rd_ptr_r[AW-1:0]),
    .rdata (data_out)
  );

`ifdef SYNC_FIFO_ERR_EN
  logic ovf_r;
  logic unf_r;

  // Sticky error flags; a new error in the clear cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      if (write_en & full_r) begin
        ovf_r <= 1'b1;
      end else if (err_clr) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end

      if (read_en & empty_r) begin
        unf_r <= 1'b1;
      end else if (err_clr) begin
        unf_r <= 1'b0;
      end else begin
        unf_r <= unf_r;
      end
    end
  end

  assign overflow  = ovf_r;
  assign underflow = unf_r;
`else
  // Error tracking is compiled out; err_clr has no effect in this build.
  assign overflow  = err_clr & 1'b0;
  assign underflow = 1'b0;
`endif

  assign full         = full_r;
  assign empty        = empty_r;
  assign almost_full  = af_r;
  assign almost_empty = ae_r;
  assign count        = count_r;

endmodule : sync_fifo_param

// File: tb/tb_sync_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_param
// Self-checking bench for sync_fifo_param (DATA_W=8, DEPTH=16). A queue-based
// reference model predicts acceptance, occupancy and flags; read data is
// pushed to a scoreboard and compared by an independent monitor process.
// ---------------------------------------------------------------------------
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

`ifdef SYNC_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          write_en;
  logic [DW-1:0] data_in;
  logic          read_en;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [4:0]    count;
  logic          overflow;
  logic          underflow;
  logic          err_clr;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] model_q [$];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_last = 8'h00;
  bit            ovf_m = 1'b0;
  bit            unf_m = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .AF_LVL (AF),
    .AE_LVL (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .write_en     (write_en),
    .data_in      (data_in),
    .read_en      (read_en),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_status();
    int sz;
    sz = model_q.size();
    chk("count", 32'(count), 32'(sz));
    chk("full", 32'(full), 32'(sz == DEPTH));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("almost_full", 32'(almost_full), 32'(sz >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(sz <= AE));
    chk("overflow", 32'(overflow), 32'(ERR_EN ? ovf_m : 1'b0));
    chk("underflow", 32'(underflow), 32'(ERR_EN ? unf_m : 1'b0));
  endtask

  // One clock of stimulus; model is updated from the pre-edge occupancy.
  task automatic cycle(input bit we, input logic [DW-1:0] d, input bit re, input bit clr);
    int  sz;
    bit  wr_ok;
    bit  rd_ok;
    write_en = we;
    data_in  = d;
    read_en  = re;
    err_clr  = clr;
    sz    = model_q.size();
    wr_ok = we && (sz < DEPTH);
    rd_ok = re && (sz > 0);
    ovf_m = (we && sz == DEPTH) ? 1'b1 : (clr ? 1'b0 : ovf_m);
    unf_m = (re && sz == 0) ? 1'b1 : (clr ? 1'b0 : unf_m);
    if (rd_ok) exp_q.push_back(model_q.pop_front());
    if (wr_ok) model_q.push_back(d);
    @(posedge clk);
    @(negedge clk);
    check_status();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted between edges, checked before the next edge.
  task automatic do_reset();
    #2;
    rst      = 1'b0;
    write_en = 1'b0;
    read_en  = 1'b0;
    err_clr  = 1'b0;
    model_q.delete();
    exp_q.delete();
    exp_last = 8'h00;
    ovf_m    = 1'b0;
    unf_m    = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_almost_empty", 32'(almost_empty), 32'd1);
    chk("rst_almost_full", 32'(almost_full), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: an accepted read at an edge presents data on the next negedge.
  initial begin
    bit rd;
    forever begin
      @(posedge clk);
      rd = rst && read_en && !empty;
      @(negedge clk);
      if (rd) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underrun: read with no expected data at %0t", $time);
        end else begin
          exp_last = exp_q.pop_front();
        end
      end
      chk("data_out", 32'(data_out), 32'(exp_last));
    end
  end

  initial begin
    rst      = 1'b0;
    write_en = 1'b0;
    read_en  = 1'b0;
    err_clr  = 1'b0;
    data_in  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check_status();
    rst = 1'b1;
    idle(1);

    // Fill 0x00..0x0F; model checks almost_full at 14 and full at 16.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    // Write while full is rejected and flagged.
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Drain, then one read while empty.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    idle(1);
    // Set and clear in the same cycle: set wins.
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Simultaneous access at count 8, then at full.
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h50 + i), 1'b1, 1'b0);
    while (model_q.size() < DEPTH) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    cycle(1'b1, 8'hBB, 1'b1, 1'b0);
    while (model_q.size() > 0) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    // Simultaneous access while empty: only the write lands.
    cycle(1'b1, 8'hCC, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Pointer wrap-around.
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomised traffic with phases biased toward full, balanced and empty.
    for (int i = 0; i < 1500; i++) begin
      int wp;
      case ((i / 150) % 3)
        0:       wp = 80;
        1:       wp = 50;
        default: wp = 20;
      endcase
      if (i == 700) begin
        do_reset();
      end
      cycle($urandom_range(0, 99) < wp, 8'($urandom_range(0, 255)),
            $urandom_range(0, 99) < (100 - wp), $urandom_range(0, 19) == 0);
    end

    while (model_q.size() > 0) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    idle(2);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sync_fifo_param

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO. It generalises the team's 16x8 buffer to configurable data width and depth, and adds:

- simultaneous read and write in one cycle,
- an occupancy count,
- programmable almost-full and almost-empty thresholds,
- optional sticky overflow and underflow error flags.

It sits between any producer and consumer that share one clock domain, for example UART byte buffering or a command queue.

## Interface
Parameters:
- DATA_W, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; must be a power of two and ≥4
- AF_LVL, DEPTH-2, almost_full asserts when count ≥ AF_LVL
- AE_LVL, 2, almost_empty asserts when count ≤ AE_LVL

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-low reset
- write_en  in  1  write request
- data_in  in  DATA_W  write data
- read_en  in  1  read request
- data_out  out  DATA_W  registered read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LVL
- almost_empty  out  1  count ≤ AE_LVL
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was attempted while full (SYNC_FIFO_ERR_EN only)
- underflow  out  1  sticky: a read was attempted while empty (SYNC_FIFO_ERR_EN only)
- err_clr  in  1  clears overflow and underflow (SYNC_FIFO_ERR_EN only)

## Operation
- Reset (rst=0, applied asynchronously):
  - pointers = 0, count = 0, data_out = 0
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0
  - overflow = 0, underflow = 0
  - Storage is not reset; its contents are don't-care.
- Pointers: write and read pointers are each AW+1 bits wide, with AW = $clog2(DEPTH).
  - The extra MSB is a wrap bit. Indexing uses the low AW bits, which wrap naturally modulo DEPTH.
  - Full is detected when the MSBs differ and the low bits are equal. Empty is detected when the pointers are equal.
- Acceptance: wr_ok = write_en & ~full; rd_ok = read_en & ~empty. Both are evaluated against the pre-edge state.
- Count update:
  - count += 1 on wr_ok & ~rd_ok
  - count -= 1 on rd_ok & ~wr_ok
  - unchanged when both or neither are accepted
- Simultaneous requests:
  - When full: the read is accepted and the write is rejected.
  - When empty: the write is accepted and the read is rejected. There is no write-to-read bypass.
  - Otherwise both are accepted and count holds.
- A rejected request changes no state other than the error flags.
- Order: data is read out strictly in the order it was written (FIFO).
- Status flags: all are registered and derived from the post-edge count, so they are consistent with count in every cycle.
- Error flags:
  - overflow is set on write_en & full; underflow is set on read_en & empty.
  - err_clr clears both. If a set and err_clr occur in the same cycle, the set wins.

## Timing
- Write: data_in is captured on the edge where wr_ok holds. count, flags and empty reflect the write from the next cycle onward.
- Read latency is 1 cycle. data_out shows the entry at the read pointer on the edge after rd_ok, and holds its value when no read is accepted.
- Write-to-read latency is 2 cycles: write at edge N, empty falls after edge N, read at edge N+1, data valid after edge N+1.
- Reset deasserted mid-operation: the FIFO resumes from the empty state on the first rising clk edge after release.

## Configuration
- Macro: SYNC_FIFO_ERR_EN.
- Defined: overflow and underflow are implemented as sticky registers, and err_clr is honoured.
- Undefined: overflow and underflow are tied to 0, err_clr is ignored, and no error logic is synthesised. All other behaviour is identical.

## Structure
- Package fifo_pkg holds:
  - the default width and depth constants,
  - a pointer-width function built on $clog2,
  - a count typedef sized $clog2(DEPTH)+1.
- Sub-module fifo_ram: DEPTH x DATA_W storage with one synchronous write port and one synchronous registered read port. The top level owns the pointers, count, flags and acceptance logic.

## Test plan
- Reset: assert rst=0 mid-stream → empty=1, full=0, count=0, data_out=0 asynchronously, before the next edge.
- Fill (DATA_W=8, DEPTH=16): write 0x00..0x0F → full=1 after the 16th write, count=16. almost_full rises after the 14th write.
- Overflow: a 17th write of 0xAA while full → overflow=1, count stays 16, 0xAA never appears on data_out. err_clr → overflow=0.
- Drain: 16 reads → data_out sequence 0x00..0x0F, empty=1 after the 16th read. A 17th read → underflow=1 and data_out holds 0x0F.
- Simultaneous access: at count=8, assert write_en and read_en for 5 cycles → count stays 8 and the output order is preserved. When full, both asserted → count drops to 15.
- Wrap-around: write 10 and read 10, then write 16 → full=1, and reading out returns exactly the 16 values in write order across the pointer wrap.
